// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-locking arbiter sharing one FIFO write port among several producers.
// Every pushed word carries its source index so the read side can demultiplex.
module fifo_write_arbiter #(
    parameter int NumRequesters = 4,
    parameter int Width         = 8,
    parameter int MaxBurst      = 16,
    localparam int IdxWidth     = $clog2(NumRequesters)
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [NumRequesters-1:0]        req_valid_i,
    input  logic [NumRequesters-1:0]        req_last_i,
    input  logic [NumRequesters*Width-1:0]  req_data_i,
    output logic [NumRequesters-1:0]        req_ready_o,
    output logic                            grant_valid_o,
    output logic [IdxWidth-1:0]             grant_idx_o,
    output logic                            fifo_write_req_o,
    input  logic                            fifo_write_valid_i,
    output logic [IdxWidth+Width-1:0]       fifo_data_o
);

    localparam int CntWidth = $clog2(MaxBurst + 1);

    typedef enum logic {
        IDLE,
        GRANTED
    } state_t;

    state_t                state_q;
    logic [IdxWidth-1:0]   grant_q;
    logic [IdxWidth-1:0]   last_grant_q;
    logic [CntWidth-1:0]   beat_cnt_q;

    logic [IdxWidth-1:0]   cand;
    logic [IdxWidth-1:0]   next_grant;
    logic                  next_found;
    logic                  granted;
    logic                  transfer;
    logic                  burst_end;

    function automatic logic [IdxWidth-1:0] wrap_idx(input int base, input int offset);
        return IdxWidth'((base + offset) % NumRequesters);
    endfunction

    // Search upward from the requester after the previous winner, wrapping once.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        cand       = '0;
        next_grant = '0;
        next_found = 1'b0;
        for (int i = 1; i <= NumRequesters; i++) begin
            cand = wrap_idx(int'(last_grant_q), i);
            if (!next_found && req_valid_i[cand]) begin
                next_found = 1'b1;
                next_grant = cand;
            end
        end
    end

    // Reset also gates the outputs so nothing transfers during the reset cycle.
    assign granted = (state_q == GRANTED) && !rst_i;

    always_comb begin
        req_ready_o      = '0;
        grant_valid_o    = 1'b0;
        grant_idx_o      = '0;
        fifo_write_req_o = 1'b0;
        fifo_data_o      = '0;
        if (granted) begin
            grant_valid_o          = 1'b1;
            grant_idx_o            = grant_q;
            fifo_write_req_o       = req_valid_i[grant_q];
            req_ready_o[grant_q]   = fifo_write_valid_i;
            fifo_data_o            = {grant_q, req_data_i[int'(grant_q)*Width +: Width]};
        end
    end

    assign transfer  = fifo_write_req_o && fifo_write_valid_i;
    assign burst_end = req_last_i[grant_q] || (beat_cnt_q == CntWidth'(MaxBurst - 1));

    // NOTE: state registers use non-blocking assignments so all updates take effect together at the edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= IdxWidth'(NumRequesters - 1);
            beat_cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (next_found) begin
                        grant_q    <= next_grant;
                        beat_cnt_q <= '0;
                        state_q    <= GRANTED;
                    end
                end
                GRANTED: begin
                    if (transfer) begin
                        if (burst_end) begin
                            state_q      <= IDLE;
                            last_grant_q <= grant_q;
                            beat_cnt_q   <= '0;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + CntWidth'(1);
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench for fifo_write_arbiter: directed vector table, hand-written
// corner sequences, then random traffic against a queue-based reference model.
module tb_fifo_write_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int MB = 16;
    localparam int IW = 2;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [N-1:0]      req_valid_i;
    logic [N-1:0]      req_last_i;
    logic [N*W-1:0]    req_data_i;
    logic [N-1:0]      req_ready_o;
    logic              grant_valid_o;
    logic [IW-1:0]     grant_idx_o;
    logic              fifo_write_req_o;
    logic              fifo_write_valid_i;
    logic [IW+W-1:0]   fifo_data_o;

    int checks = 0;
    int errors = 0;

    fifo_write_arbiter #(
        .NumRequesters(N),
        .Width(W),
        .MaxBurst(MB)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .req_valid_i(req_valid_i),
        .req_last_i(req_last_i),
        .req_data_i(req_data_i),
        .req_ready_o(req_ready_o),
        .grant_valid_o(grant_valid_o),
        .grant_idx_o(grant_idx_o),
        .fifo_write_req_o(fifo_write_req_o),
        .fifo_write_valid_i(fifo_write_valid_i),
        .fifo_data_o(fifo_data_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic         rst;
        logic [N-1:0] valid;
        logic [N-1:0] last;
        logic         fok;
        logic         gv;
        logic [IW-1:0] idx;
        logic         wreq;
        logic [N-1:0] rdy;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [IW+W-1:0] word_of(input int idx);
        return {IW'(idx), req_data_i[idx*W +: W]};
    endfunction

    // Compare all outputs at the falling edge, then move to just after the next rising edge.
    task automatic expect_cycle(input string name, input logic gv, input logic [IW-1:0] idx,
                                input logic wreq, input logic [N-1:0] rdy);
        logic [IW+W-1:0] exp_data;
        @(negedge clk_i);
        exp_data = gv ? word_of(int'(idx)) : '0;
        check(name,
              64'({grant_valid_o, grant_idx_o, fifo_write_req_o, req_ready_o, fifo_data_o}),
              64'({gv, idx, wreq, rdy, exp_data}));
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic rst, input logic [N-1:0] valid, input logic [N-1:0] last,
                         input logic fok);
        rst_i              = rst;
        req_valid_i        = valid;
        req_last_i         = last;
        fifo_write_valid_i = fok;
    endtask

    // Reference model state for the random phase.
    int              m_owner;
    int              m_beats;
    int              m_last;
    logic [N-1:0]    pend;
    logic [N-1:0]    plast;
    logic [W-1:0]    pdata [N];
    logic [IW+W-1:0] gen_q [N][$];
    logic [IW+W-1:0] fifo_q[$];

    initial begin
        req_data_i = {8'h3C, 8'hA5, 8'h5A, 8'h11};
        drive(1'b1, '0, '0, 1'b1);

        // Reset, single request, round robin, backpressure.
        vecs.push_back('{1'b1, 4'b0100, 4'b0100, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000});
        vecs.push_back('{1'b0, 4'b0100, 4'b0100, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000});
        vecs.push_back('{1'b0, 4'b0100, 4'b0100, 1'b1, 1'b1, 2'd2, 1'b1, 4'b0100});
        vecs.push_back('{1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000});
        vecs.push_back('{1'b1, 4'b1111, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000});
        vecs.push_back('{1'b0, 4'b1111, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000});
        vecs.push_back('{1'b0, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001});
        vecs.push_back('{1'b0, 4'b1111, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000});
        vecs.push_back('{1'b0, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0010});
        vecs.push_back('{1'b0, 4'b1111, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000});
        vecs.push_back('{1'b0, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd2, 1'b1, 4'b0100});
        vecs.push_back('{1'b0, 4'b1111, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000});
        vecs.push_back('{1'b0, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd3, 1'b1, 4'b1000});
        vecs.push_back('{1'b0, 4'b1111, 4'b1111, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000});
        vecs.push_back('{1'b0, 4'b1111, 4'b1111, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001});
        vecs.push_back('{1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000});
        vecs.push_back('{1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000});
        vecs.push_back('{1'b0, 4'b0001, 4'b0000, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001});
        vecs.push_back('{1'b0, 4'b0001, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0000});
        vecs.push_back('{1'b0, 4'b0001, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0000});
        vecs.push_back('{1'b0, 4'b0001, 4'b0000, 1'b0, 1'b1, 2'd0, 1'b1, 4'b0000});
        vecs.push_back('{1'b0, 4'b0001, 4'b0001, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001});
        vecs.push_back('{1'b0, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000});

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].valid, vecs[i].last, vecs[i].fok);
            expect_cycle($sformatf("vec%0d", i), vecs[i].gv, vecs[i].idx, vecs[i].wreq, vecs[i].rdy);
        end

        // Burst cap: requester 1 streams 20 beats without last; cut at 16, then resumes.
        drive(1'b0, 4'b0010, 4'b0000, 1'b1);
        expect_cycle("cap_arb", 1'b0, 2'd0, 1'b0, 4'b0000);
        for (int b = 0; b < 20; b++) begin
            req_data_i[1*W +: W] = W'(8'h40 + b);
            req_last_i           = (b == 19) ? 4'b0010 : 4'b0000;
            if (b == 16) expect_cycle("cap_gap", 1'b0, 2'd0, 1'b0, 4'b0000);
            expect_cycle($sformatf("cap_beat%0d", b), 1'b1, 2'd1, 1'b1, 4'b0010);
        end
        drive(1'b0, 4'b0000, 4'b0000, 1'b1);
        expect_cycle("cap_done", 1'b0, 2'd0, 1'b0, 4'b0000);

        // Burst cap with requester 3 waiting: 3 wins after the 16th beat.
        drive(1'b0, 4'b0010, 4'b0000, 1'b1);
        expect_cycle("cap2_arb", 1'b0, 2'd0, 1'b0, 4'b0000);
        for (int b = 0; b < 16; b++)
            expect_cycle($sformatf("cap2_beat%0d", b), 1'b1, 2'd1, 1'b1, 4'b0010);
        drive(1'b0, 4'b1010, 4'b1000, 1'b1);
        expect_cycle("cap2_gap", 1'b0, 2'd0, 1'b0, 4'b0000);
        expect_cycle("cap2_r3", 1'b1, 2'd3, 1'b1, 4'b1000);
        drive(1'b0, 4'b0010, 4'b0010, 1'b1);
        expect_cycle("cap2_gap2", 1'b0, 2'd0, 1'b0, 4'b0000);
        expect_cycle("cap2_r1", 1'b1, 2'd1, 1'b1, 4'b0010);
        drive(1'b0, 4'b0000, 4'b0000, 1'b1);
        expect_cycle("cap2_done", 1'b0, 2'd0, 1'b0, 4'b0000);

        // Valid gap: requester 0 bubbles while requester 2 waits.
        drive(1'b1, 4'b0000, 4'b0000, 1'b1);
        expect_cycle("gap_rst", 1'b0, 2'd0, 1'b0, 4'b0000);
        drive(1'b0, 4'b0101, 4'b0000, 1'b1);
        expect_cycle("gap_arb", 1'b0, 2'd0, 1'b0, 4'b0000);
        expect_cycle("gap_b0", 1'b1, 2'd0, 1'b1, 4'b0001);
        expect_cycle("gap_b1", 1'b1, 2'd0, 1'b1, 4'b0001);
        drive(1'b0, 4'b0100, 4'b0000, 1'b1);
        expect_cycle("gap_hold0", 1'b1, 2'd0, 1'b0, 4'b0001);
        expect_cycle("gap_hold1", 1'b1, 2'd0, 1'b0, 4'b0001);
        drive(1'b0, 4'b0101, 4'b0001, 1'b1);
        expect_cycle("gap_last", 1'b1, 2'd0, 1'b1, 4'b0001);
        drive(1'b0, 4'b0100, 4'b0100, 1'b1);
        expect_cycle("gap_idle", 1'b0, 2'd0, 1'b0, 4'b0000);
        expect_cycle("gap_r2", 1'b1, 2'd2, 1'b1, 4'b0100);
        drive(1'b0, 4'b0000, 4'b0000, 1'b1);
        expect_cycle("gap_done", 1'b0, 2'd0, 1'b0, 4'b0000);

        // Reset mid-burst: requester 1 is cut after 3 beats, requester 0 wins afterwards.
        drive(1'b0, 4'b0010, 4'b0000, 1'b1);
        expect_cycle("rmb_arb", 1'b0, 2'd0, 1'b0, 4'b0000);
        for (int b = 0; b < 3; b++)
            expect_cycle($sformatf("rmb_beat%0d", b), 1'b1, 2'd1, 1'b1, 4'b0010);
        drive(1'b1, 4'b0011, 4'b0001, 1'b1);
        expect_cycle("rmb_rst", 1'b0, 2'd0, 1'b0, 4'b0000);
        drive(1'b0, 4'b0011, 4'b0001, 1'b1);
        expect_cycle("rmb_idle", 1'b0, 2'd0, 1'b0, 4'b0000);
        expect_cycle("rmb_r0", 1'b1, 2'd0, 1'b1, 4'b0001);
        drive(1'b0, 4'b0010, 4'b0010, 1'b1);
        expect_cycle("rmb_idle2", 1'b0, 2'd0, 1'b0, 4'b0000);
        expect_cycle("rmb_r1", 1'b1, 2'd1, 1'b1, 4'b0010);
        drive(1'b0, 4'b0000, 4'b0000, 1'b1);
        expect_cycle("rmb_done", 1'b0, 2'd0, 1'b0, 4'b0000);

        // Random traffic against the reference model.
        m_owner = -1;
        m_beats = 0;
        m_last  = N - 1;
        pend    = '0;
        plast   = '0;
        for (int k = 0; k < N; k++) pdata[k] = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic            rst;
            logic            fok;
            logic            e_gv;
            logic [IW-1:0]   e_idx;
            logic            e_wreq;
            logic [N-1:0]    e_rdy;
            logic [IW+W-1:0] e_data;

            rst = (cyc == 0) || ($urandom_range(0, 299) == 0);
            fok = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < N; k++) begin
                if (!pend[k] && $urandom_range(0, 2) == 0) begin
                    pend[k]  = 1'b1;
                    pdata[k] = W'($urandom);
                    plast[k] = ($urandom_range(0, 5) == 0);
                end
                req_data_i[k*W +: W] = pdata[k];
            end
            drive(rst, pend, plast, fok);

            e_gv = 1'b0; e_idx = '0; e_wreq = 1'b0; e_rdy = '0; e_data = '0;
            if (!rst && m_owner >= 0) begin
                e_gv   = 1'b1;
                e_idx  = IW'(m_owner);
                e_wreq = pend[m_owner];
                e_rdy  = fok ? N'(1 << m_owner) : '0;
                e_data = {IW'(m_owner), pdata[m_owner]};
            end

            @(negedge clk_i);
            check($sformatf("rand%0d", cyc),
                  64'({grant_valid_o, grant_idx_o, fifo_write_req_o, req_ready_o, fifo_data_o}),
                  64'({e_gv, e_idx, e_wreq, e_rdy, e_data}));
            if (fifo_write_req_o && fifo_write_valid_i) fifo_q.push_back(fifo_data_o);

            if (rst) begin
                m_owner = -1;
                m_beats = 0;
                m_last  = N - 1;
            end else if (m_owner < 0) begin
                for (int i = 1; i <= N; i++) begin
                    if (m_owner < 0 && pend[(m_last + i) % N]) begin
                        m_owner = (m_last + i) % N;
                        m_beats = 0;
                    end
                end
            end else if (pend[m_owner] && fok) begin
                gen_q[m_owner].push_back({IW'(m_owner), pdata[m_owner]});
                pend[m_owner] = 1'b0;
                m_beats++;
                if (plast[m_owner] || m_beats == MB) begin
                    m_last  = m_owner;
                    m_owner = -1;
                    m_beats = 0;
                end
            end
            @(posedge clk_i);
            #1;
        end

        // Scoreboard: demultiplex the FIFO contents by tag and match each producer's stream.
        foreach (fifo_q[i]) begin
            int tag;
            tag = int'(fifo_q[i][IW+W-1:W]);
            if (gen_q[tag].size() == 0) begin
                check($sformatf("sb_extra%0d", i), 64'(fifo_q[i]), 64'(0));
            end else begin
                check($sformatf("sb_word%0d", i), 64'(fifo_q[i]), 64'(gen_q[tag].pop_front()));
            end
        end
        for (int k = 0; k < N; k++)
            check($sformatf("sb_left%0d", k), 64'(gen_q[k].size()), 64'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
Name: fifo_write_arbiter

Overview:
- Shares the single write port of a FIFO (e.g. the write side of cdc_fifo) between NumRequesters producers.
- Uses round-robin arbitration with burst locking: a granted requester keeps the port until it signals last, or until MaxBurst beats have transferred.
- Each word pushed into the FIFO is tagged with its source index, so the read-side consumer can demultiplex.
- Sits entirely in the FIFO write clock domain.

Parameters:
- NumRequesters, 4, number of producers; must be >= 2.
- Width, 8, payload width per requester.
- MaxBurst, 16, maximum beats per grant; must be >= 1. MaxBurst=1 forces per-beat rotation.
- IdxWidth (localparam), $clog2(NumRequesters), width of the source tag.

Ports:
- clk_i  input  1  clock (FIFO write clock).
- rst_i  input  1  synchronous active-high reset.
- req_valid_i  input  NumRequesters  per-requester word valid.
- req_last_i  input  NumRequesters  per-requester last-beat-of-burst flag; qualified by valid.
- req_data_i  input  NumRequesters*Width  packed payloads; requester k occupies bits [k*Width +: Width].
- req_ready_o  output  NumRequesters  per-requester accept; at most one bit set.
- grant_valid_o  output  1  a grant is held.
- grant_idx_o  output  IdxWidth  index of the current grantee; 0 when no grant is held.
- fifo_write_req_o  output  1  to FIFO write_req_i.
- fifo_write_valid_i  input  1  from FIFO write_valid_o (FIFO can accept).
- fifo_data_o  output  IdxWidth+Width  to FIFO data_i; {grant index, payload}.

Behaviour:
- Transfer definition: a beat transfers in a cycle where fifo_write_req_o && fifo_write_valid_i. This matches the FIFO's same-cycle write semantics.
- Registered state: state (IDLE/GRANTED), grant index g, last_grant, beat_cnt (width $clog2(MaxBurst+1)).
- Reset values: state=IDLE, g=0, last_grant=NumRequesters-1 (so the first winner is requester 0), beat_cnt=0. Every output is 0 while rst_i is asserted and on the first cycle after deassertion.
- Reset mid-burst: returns to IDLE the next cycle. No beat is transferred in the reset cycle. The in-progress burst is abandoned.
- IDLE:
  - All outputs 0.
  - If any req_valid_i bit is set, pick the first set bit searching upward (with wrap) from last_grant+1. Register it into g, clear beat_cnt, go to GRANTED.
  - Arbitration latency is 1 cycle: no word transfers in the IDLE cycle.
- GRANTED:
  - grant_valid_o=1 and grant_idx_o=g.
  - fifo_write_req_o = req_valid_i[g].
  - req_ready_o[g] = fifo_write_valid_i; all other ready bits are 0.
  - fifo_data_o = {g, req_data_i[g]}.
  - All of the above are combinational from the registered g and current inputs.
- On a transfer in GRANTED:
  - If req_last_i[g] is set or beat_cnt==MaxBurst-1: go to IDLE, set last_grant=g, clear beat_cnt.
  - Otherwise: beat_cnt++.
- Grantee drops valid mid-burst: the grant is held and bubbles are allowed; no timeout.
- FIFO full (fifo_write_valid_i=0): req_ready_o[g]=0 and the data is held by the requester; no state change.
- Back-to-back bursts: there is always one IDLE cycle between grants, including when the same requester re-requests. Rotation guarantees the other requesters are served first if they are valid in that IDLE cycle.
- Non-granted requesters must hold valid/data stable until accepted. Violations are not checked.
- Throughput: at most MaxBurst beats per MaxBurst+1 cycles under continuous requests.

Test Plan:
- Reset then single request: req_valid_i=4'b0100, last=1, data 8'hA5, FIFO ready.
  -> cycle 1 IDLE, no output.
  -> cycle 2 grant_idx_o=2, fifo_write_req_o=1, fifo_data_o={2'd2,8'hA5}, req_ready_o=4'b0100.
  -> cycle 3 back in IDLE.
- Round-robin: all four requesters valid with last=1 on every beat.
  -> grant order is 0,1,2,3,0.
  -> each grant is separated by one IDLE cycle.
- Burst cap (MaxBurst=16): requester 1 streams 20 beats with last=0.
  -> exactly 16 transfers, then IDLE.
  -> requester 3, if valid, wins next; otherwise requester 1 resumes and sends the remaining 4.
- FIFO backpressure: during a grant to requester 0, fifo_write_valid_i=0 for 3 cycles.
  -> req_ready_o=0 and beat_cnt is unchanged.
  -> transfer resumes when fifo_write_valid_i returns to 1, with no data loss or duplication (scoreboard against the FIFO contents).
- Valid gap: the grantee deasserts valid for 2 cycles mid-burst while requester 2 is valid.
  -> grant is held and fifo_write_req_o=0 during the gap.
  -> requester 2 is granted only after the grantee's last beat.
- Reset mid-burst: assert rst_i after 3 of 8 beats.
  -> outputs go to 0 the next cycle.
  -> after release, requester 0 has priority, since last_grant is reset.
